// File: rtl/apb_req_arbiter_if.sv
// Requester-side and APB-observe signals of the round-robin APB request arbiter.
// The arbiter takes the slave view; requesters and the bus take the master view.
interface apb_req_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_write;
    logic [32*NREQ-1:0]   req_addr;
    logic [32*NREQ-1:0]   req_wdata;
    logic [4*NREQ-1:0]    req_strb;
    logic [3*NREQ-1:0]    req_prot;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [31:0]          rdata;
    logic                 slverr;
    logic                 busy;
    logic                 timeout_err;
    logic                 transfer;
    logic                 SWRITE;
    logic [31:0]          SADDR;
    logic [31:0]          SWDATA;
    logic [3:0]           SSTRB;
    logic [2:0]           SPROT;
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PREADY;
    logic [31:0]          PRDATA;
    logic                 PSLVERR;

    modport slave (
        input  req, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  PSEL, PENABLE, PREADY, PRDATA, PSLVERR,
        output gnt, done, rdata, slverr, busy, timeout_err,
        output transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT
    );

    modport master (
        output req, req_write, req_addr, req_wdata, req_strb, req_prot,
        output PSEL, PENABLE, PREADY, PRDATA, PSLVERR,
        input  gnt, done, rdata, slverr, busy, timeout_err,
        input  transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master between NREQ requesters.
// Latches the winner's fields, drives the master and returns completion status.
module apb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input logic          PCLK,
    input logic          PRESET,
    apb_req_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] TO = 16'(TIMEOUT);

    localparam logic [1:0] ARB   = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]      state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [15:0]     wait_cnt;

    logic            found;
    logic [IW-1:0]   win;
    logic [NREQ-1:0] win_oh;
    logic            w_write;
    logic [31:0]     w_addr;
    logic [31:0]     w_wdata;
    logic [3:0]      w_strb;
    logic [2:0]      w_prot;

    logic setup_seen;
    logic access;
    logic stall;

    assign setup_seen = bus.PSEL & ~bus.PENABLE;
    assign access     = bus.PSEL & bus.PENABLE;
    assign stall      = access & ~bus.PREADY;

    // Search starts at rr_ptr and wraps explicitly so non-power-of-2 NREQ works.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int s;
            logic [IW-1:0] idx;
            s = int'(rr_ptr) + k;
            if (s >= NREQ) s = s - NREQ;
            idx = s[IW-1:0];
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_oh  = '0;
        w_write = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_strb  = '0;
        w_prot  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                win_oh[i] = 1'b1;
                w_write   = bus.req_write[i];
                w_addr    = bus.req_addr[32*i +: 32];
                w_wdata   = bus.req_wdata[32*i +: 32];
                w_strb    = bus.req_strb[4*i +: 4];
                w_prot    = bus.req_prot[3*i +: 3];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state           <= ARB;
            rr_ptr          <= '0;
            owner           <= '0;
            wait_cnt        <= '0;
            bus.gnt         <= '0;
            bus.done        <= '0;
            bus.rdata       <= '0;
            bus.slverr      <= 1'b0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.transfer    <= 1'b0;
            bus.SWRITE      <= 1'b0;
            bus.SADDR       <= '0;
            bus.SWDATA      <= '0;
            bus.SSTRB       <= '0;
            bus.SPROT       <= '0;
        end else begin
            bus.done <= '0;
            case (state)
                ARB: begin
                    if (found) begin
                        owner        <= win;
                        bus.gnt      <= win_oh;
                        bus.SWRITE   <= w_write;
                        bus.SADDR    <= w_addr;
                        bus.SWDATA   <= w_wdata;
                        bus.SSTRB    <= w_strb;
                        bus.SPROT    <= w_prot;
                        bus.transfer <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= ISSUE;
                    end else begin
                        bus.transfer <= 1'b0;
                    end
                end
                // Drop transfer in SETUP so the master idles after this access.
                ISSUE: begin
                    if (setup_seen) begin
                        bus.transfer <= 1'b0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (access && bus.PREADY) begin
                        bus.rdata  <= bus.PRDATA;
                        bus.slverr <= bus.PSLVERR;
                        bus.done   <= bus.gnt;
                        bus.gnt    <= '0;
                        bus.busy   <= 1'b0;
                        rr_ptr     <= (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;
                        wait_cnt   <= '0;
                        state      <= ARB;
                    end else if (stall && wait_cnt != TO) begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (wait_cnt + 16'd1 == TO) bus.timeout_err <= 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule
